// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the 8-bit SRAM FIFO and its serial drain stage.
// master = the drain (issues pops), slave = the FIFO (supplies data and ready).
interface fifo_uart_tx_if;
  logic       fifo_ready;
  logic [7:0] fifo_data;
  logic       fifo_read;

  modport master (
    input  fifo_ready,
    input  fifo_data,
    output fifo_read
  );

  modport slave (
    output fifo_ready,
    output fifo_data,
    input  fifo_read
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte, then shifts it out as a UART frame (start, 8 data LSB first, stop).
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE_LAST = BAUD_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                fifo_read_q, fifo_read_d;
  logic                frame_done_q, frame_done_d;

  logic                start_ok;
  logic                bit_end;
  logic [2:0]          bit_nxt;
  logic [BAUD_W-1:0]   baud_inc;

  assign start_ok = enable & fifo.fifo_ready;
  assign bit_end  = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;
  assign baud_inc = baud_q + BAUD_W'(1);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    fifo_read_d  = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start_ok) begin
          state_d     = S_REQ;
          fifo_read_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      S_REQ: begin
        state_d = S_LOAD;
      end

      // The popped byte is on fifo_data during this cycle; it is committed even if ready dropped.
      S_LOAD: begin
        shift_d = fifo.fifo_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = 3'd0;
        state_d = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_inc;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          bit_d  = bit_nxt;
          if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_inc;
        end
      end

`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_inc;
        end
      end
`endif

      // frame_done is registered, so it is requested one cycle ahead to land on the last stop cycle.
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (start_ok) begin
            state_d     = S_REQ;
            fifo_read_d = 1'b1;
            busy_d      = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d       = baud_inc;
          frame_done_d = (baud_q == BAUD_PRE_LAST);
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!clrn) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      fifo_read_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      fifo_read_q  <= fifo_read_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo.fifo_read = fifo_read_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

  // A pop is never held for two cycles, and the line only leaves idle-high while busy.
  a_read_single: assert property (@(posedge clk) disable iff (!clrn) fifo_read_q |=> !fifo_read_q);
  a_idle_high:   assert property (@(posedge clk) disable iff (!clrn) !busy_q |-> tx_q);
  a_done_busy:   assert property (@(posedge clk) disable iff (!clrn) frame_done_q |-> busy_q);

endmodule
